// File: rtl/au_div.sv
// au_div: 16-bit signed restoring divider, one quotient bit per cycle.
// Saturates on overflow and divide-by-zero; results held until the next completion.
module au_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Quotient,
  output logic [15:0] Remainder,
  output logic        busy,
  output logic        done,
  output logic        v,
  output logic        dz,
  output logic        n,
  output logic        z
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] dvd;
  logic [15:0] bmag;
  logic [15:0] pr;
  logic [3:0]  cnt;
  logic        sa;
  logic        sb;
  logic        pend;
  logic [15:0] sq;
  logic [15:0] sr;
  logic        sv;
  logic        sdz;

  logic [15:0] amag_in;
  logic [15:0] bmag_in;
  logic        div0;
  logic        ovf;
  logic        special;
  logic        accept;
  logic [16:0] trial;
  logic [15:0] q_fix;
  logic [15:0] r_fix;

  assign amag_in = A[15] ? (~A + 16'd1) : A;
  assign bmag_in = B[15] ? (~B + 16'd1) : B;
  assign div0    = (B == 16'h0000);
  assign ovf     = (A == 16'h8000) && (B == 16'hFFFF);
  assign special = div0 || ovf;
  assign accept  = start && (state == IDLE) && !pend;
  assign busy    = (state != IDLE);

  // PR stays below |B| <= 0x8000, so 16 bits plus the shifted-in bit suffice.
  assign trial = {pr, dvd[15]} - {1'b0, bmag};
  assign q_fix = (sa ^ sb) ? (~dvd + 16'd1) : dvd;
  assign r_fix = sa ? (~pr + 16'd1) : pr;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && !special) state_nx = CALC;
      CALC: if (cnt == 4'd15) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dvd       <= '0;
      bmag      <= '0;
      pr        <= '0;
      cnt       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      pend      <= 1'b0;
      sq        <= '0;
      sr        <= '0;
      sv        <= 1'b0;
      sdz       <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      done      <= 1'b0;
      v         <= 1'b0;
      dz        <= 1'b0;
      n         <= 1'b0;
      z         <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (accept) begin
        sa   <= A[15];
        sb   <= B[15];
        dvd  <= amag_in;
        bmag <= bmag_in;
        pr   <= '0;
        cnt  <= '0;
        pend <= special;
        sv   <= ovf && !div0;
        sdz  <= div0;
        if (div0) begin
          sq <= A[15] ? 16'h8000 : 16'h7FFF;
          sr <= A;
        end else begin
          sq <= 16'h7FFF;
          sr <= 16'h0000;
        end
      end
      // Special results go out one edge after capture, without entering CALC.
      if (pend) begin
        pend      <= 1'b0;
        Quotient  <= sq;
        Remainder <= sr;
        v         <= sv;
        dz        <= sdz;
        n         <= sq[15];
        z         <= (sq == 16'h0000);
        done      <= 1'b1;
      end
      if (state == CALC) begin
        cnt <= cnt + 4'd1;
        if (!trial[16]) begin
          pr  <= trial[15:0];
          dvd <= {dvd[14:0], 1'b1};
        end else begin
          pr  <= {pr[14:0], dvd[15]};
          dvd <= {dvd[14:0], 1'b0};
        end
      end
      if (state == FIX) begin
        Quotient  <= q_fix;
        Remainder <= r_fix;
        v         <= 1'b0;
        dz        <= 1'b0;
        n         <= q_fix[15];
        z         <= (q_fix == 16'h0000);
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_au_div.sv
// tb_au_div: table-driven checks of au_div results, flags and latency,
// plus hand sequences for start-while-busy and reset abort.
module tb_au_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Quotient;
  logic [15:0] Remainder;
  logic        busy;
  logic        done;
  logic        v;
  logic        dz;
  logic        n;
  logic        z;

  always #5 clk = ~clk;

  au_div dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A(A),
    .B(B),
    .Quotient(Quotient),
    .Remainder(Remainder),
    .busy(busy),
    .done(done),
    .v(v),
    .dz(dz),
    .n(n),
    .z(z)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        v;
    logic        dz;
    logic        n;
    logic        z;
    int          lat;
  } vec_t;

  vec_t tbl[14];
  int   nvec = 0;
  int   nmis = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic busy0);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'hDEAD;
    B = 16'h0BAD;
    lat = 0;
    busy0 = busy;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int          lat;
    logic        busy0;
    logic [7:0]  lat8;
    int          ndone;
    logic [31:0] res;
    vec_t        t;

    tbl[0]  = '{16'd100,  16'd7,    16'h000E, 16'h0002, 0, 0, 0, 0, 17};
    tbl[1]  = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 0, 0, 1, 0, 17};
    tbl[2]  = '{16'd3,    16'd5,    16'h0000, 16'h0003, 0, 0, 0, 1, 17};
    tbl[3]  = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1, 0, 0, 0, 1};
    tbl[4]  = '{16'h8000, 16'h0001, 16'h8000, 16'h0000, 0, 0, 1, 0, 17};
    tbl[5]  = '{16'd5,    16'h0000, 16'h7FFF, 16'h0005, 0, 1, 0, 0, 1};
    tbl[6]  = '{16'hFFFB, 16'h0000, 16'h8000, 16'hFFFB, 0, 1, 1, 0, 1};
    tbl[7]  = '{16'd9,    16'd3,    16'h0003, 16'h0000, 0, 0, 0, 0, 17};
    tbl[8]  = '{16'd7,    16'hFFFE, 16'hFFFD, 16'h0001, 0, 0, 1, 0, 17};
    tbl[9]  = '{16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 0, 0, 0, 0, 17};
    tbl[10] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 0, 0, 0, 1, 17};
    tbl[11] = '{16'h8000, 16'h8000, 16'h0001, 16'h0000, 0, 0, 0, 0, 17};
    tbl[12] = '{16'h8000, 16'hFFFE, 16'h4000, 16'h0000, 0, 0, 0, 0, 17};
    tbl[13] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 0, 1, 0, 0, 1};

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    chk("reset", {Quotient, Remainder, busy, done, v, dz, n, z}, '0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      t = tbl[i];
      run_op(t.a, t.b, lat, busy0);
      lat8 = lat[7:0];
      chk($sformatf("vec%0d %h/%h", i, t.a, t.b),
          {Quotient, Remainder, v, dz, n, z, busy, lat8},
          {t.q, t.r, t.v, t.dz, t.n, t.z, 1'b0, 8'(t.lat)});
      chk($sformatf("vec%0d busy", i), {63'd0, busy0},
          {63'd0, (t.lat > 1)});
      @(negedge clk);
      chk($sformatf("vec%0d pulse", i), {63'd0, done}, 64'd0);
    end

    // A second start during CALC must be dropped.
    @(negedge clk);
    A = 16'd100;
    B = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    res = '0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) begin
        start = 1'b1;
        A = 16'd9;
        B = 16'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (c == 3)
        chk("hold", {48'd0, Quotient}, {48'd0, tbl[13].q});
      if (done) begin
        ndone++;
        if (ndone == 1) res = {Quotient, Remainder};
      end
    end
    chk("busy-start dones", 64'(ndone), 64'd1);
    chk("busy-start result", {32'd0, res}, {32'd0, 16'h000E, 16'h0002});

    run_op(16'd9, 16'd3, lat, busy0);
    lat8 = lat[7:0];
    chk("9/3 after", {Quotient, Remainder, lat8},
        {16'h0003, 16'h0000, 8'd17});

    // Abort by reset mid-operation.
    @(negedge clk);
    A = 16'd100;
    B = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort clear", {Quotient, Remainder, busy, done, v, dz, n, z}, '0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);

    // Reset wins over a simultaneous start.
    A = 16'd100;
    B = 16'd7;
    start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    chk("rst prio busy", {63'd0, busy}, 64'd0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("rst prio idle", 64'(ndone), 64'd0);

    run_op(16'd100, 16'd7, lat, busy0);
    lat8 = lat[7:0];
    chk("100/7 final", {Quotient, Remainder, n, z, lat8},
        {16'h000E, 16'h0002, 1'b0, 1'b0, 8'd17});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
